// File: rtl/cache_rd_ctrl.sv
// rtl/cache_rd_ctrl.sv - read-path controller for a direct-mapped cache with line refill
module cache_rd_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int NUM_LINES  = 8,
  parameter int LINE_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic              cpu_hit,
  output logic [7:0]        cpu_data,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_BYTES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]           state;
  logic [ADDR_W-1:0]    req_addr;
  logic [OFF_W-1:0]     beat;
  logic                 hit_q;
  logic [7:0]           data_q;
  logic [NUM_LINES-1:0] valid_q;

  // Tags and data are never reset; only the valid bits qualify them.
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [7:0]           data_mem [NUM_LINES*LINE_BYTES];

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;
  logic [OFF_W-1:0]     req_off;
  logic                 lookup_hit;
  logic                 beat_done;
  logic                 last_beat;

  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_off = req_addr[OFF_W-1:0];

  assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign beat_done  = (state == S_REFILL) && mem_ack;
  assign last_beat  = (beat == LAST_BEAT);

  assign cpu_ready = (state == S_IDLE) && !flush;
  assign cpu_valid = (state == S_RESP);
  assign cpu_hit   = hit_q;
  assign cpu_data  = data_q;
  assign mem_req   = (state == S_REFILL);
  // The beat counter only moves on an ack, so the address holds while memory waits.
  assign mem_addr  = {req_tag, req_idx, beat};

  // Control FSM, valid bits and the response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      req_addr <= '0;
      beat     <= '0;
      hit_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (cpu_req) begin
            req_addr <= cpu_addr;
            state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (lookup_hit) begin
            data_q <= data_mem[{req_idx, req_off}];
            hit_q  <= 1'b1;
            state  <= S_RESP;
          end else begin
            beat  <= '0;
            state <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_ack) begin
            if (beat == req_off) begin
              data_q <= mem_data;
            end
            beat <= beat + 1'b1;
            // The line becomes visible only once every byte has arrived.
            if (last_beat) begin
              valid_q[req_idx] <= 1'b1;
              hit_q            <= 1'b0;
              state            <= S_RESP;
            end
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Line storage: each acked refill beat lands in the line, the tag on the last one.
  always_ff @(posedge clk) begin
    if (beat_done) begin
      data_mem[{req_idx, beat}] <= mem_data;
      if (last_beat) begin
        tag_mem[req_idx] <= req_tag;
      end
    end
  end

endmodule

// File: tb/tb_cache_rd_ctrl.sv
// tb/tb_cache_rd_ctrl.sv - randomized self-checking bench for cache_rd_ctrl
module tb_cache_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_req = 1'b0;
  logic [7:0] cpu_addr = 8'h00;
  logic       flush = 1'b0;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_data = 8'h00;
  logic       cpu_ready;
  logic       cpu_valid;
  logic       cpu_hit;
  logic [7:0] cpu_data;
  logic       mem_req;
  logic [7:0] mem_addr;

  cache_rd_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_ready (cpu_ready),
    .cpu_valid (cpu_valid),
    .cpu_hit   (cpu_hit),
    .cpu_data  (cpu_data),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         acc;
    int         due;
    logic       hit;
    logic [7:0] data;
  } resp_t;

  resp_t      rq[$];
  logic [7:0] aq[$];
  bit         m_valid[8];
  logic [2:0] m_tag[8];
  logic [7:0] held = 8'h00;
  int         mem_wait = 0;
  int         wait_cnt = 0;
  int         last_lat = 0;
  logic       last_hit = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic       exp_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Memory model: memory[i] = i, fixed wait per beat, stray acks while idle.
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      if (wait_cnt >= mem_wait) begin
        mem_ack  = 1'b1;
        mem_data = mem_addr;
        wait_cnt = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = ($urandom_range(0, 3) == 0);
      mem_data = 8'($urandom);
      wait_cnt = 0;
    end
  end

  // Compare process: DUT outputs against the transaction-level expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_mem_req", mem_req, 0);
      chk("rst_cpu_valid", cpu_valid, 0);
    end else begin
      exp_ready = !flush && (rq.size() == 0 || rq[0].acc == cyc);
      chk("cpu_ready", cpu_ready, exp_ready);
      if (cpu_valid) begin
        if (rq.size() == 0) begin
          fail("unexpected_cpu_valid");
        end else begin
          chk("resp_cycle", cyc, rq[0].due);
          chk("resp_hit", cpu_hit, rq[0].hit);
          chk("resp_data", cpu_data, rq[0].data);
          held      = rq[0].data;
          last_lat  = cyc - rq[0].acc;
          last_hit  = cpu_hit;
          last_data = cpu_data;
          void'(rq.pop_front());
        end
      end else if (rq.size() == 0) begin
        chk("data_hold", cpu_data, held);
      end else if (cyc > rq[0].due) begin
        fail("resp_timeout");
        rq.delete();
        aq.delete();
      end
      if (mem_req) begin
        if (aq.size() == 0) begin
          fail("unexpected_mem_req");
        end else begin
          chk("mem_addr", mem_addr, aq[0]);
          if (mem_ack) void'(aq.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (rq.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (rq.size() != 0) begin
      fail("wait_idle_timeout");
      rq.delete();
      aq.delete();
    end
  endtask

  task automatic start_read(input logic [7:0] a);
    logic [2:0] tg;
    logic [2:0] ix;
    logic       h;
    logic [1:0] bb;
    resp_t      r;
    tg = a[7:5];
    ix = a[4:2];
    h  = m_valid[ix] && (m_tag[ix] == tg);
    r.acc  = cyc;
    r.due  = h ? cyc + 2 : cyc + 2 + 4 * (mem_wait + 1);
    r.hit  = h;
    r.data = a;
    rq.push_back(r);
    if (!h) begin
      for (int b = 0; b < 4; b++) begin
        bb = b[1:0];
        aq.push_back({a[7:2], bb});
      end
      m_valid[ix] = 1'b1;
      m_tag[ix]   = tg;
    end
    cpu_req  = 1'b1;
    cpu_addr = a;
    tick();
    cpu_req  = 1'b0;
    cpu_addr = 8'($urandom);
  endtask

  task automatic do_read(input logic [7:0] a);
    start_read(a);
    wait_idle();
  endtask

  task automatic read_lit(input logic [7:0] a, input logic exp_hit, input int exp_lat);
    do_read(a);
    chk("lit_hit", last_hit, exp_hit);
    chk("lit_data", last_data, a);
    chk("lit_latency", last_lat, exp_lat);
  endtask

  task automatic do_flush(input logic with_req);
    flush    = 1'b1;
    cpu_req  = with_req;
    cpu_addr = 8'($urandom);
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    tick();
    flush   = 1'b0;
    cpu_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    tick();
    tick();
    chk("reset_cpu_valid", cpu_valid, 0);
    chk("reset_cpu_hit", cpu_hit, 0);
    chk("reset_cpu_data", cpu_data, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_cpu_ready", cpu_ready, 1);
    rst_n = 1'b1;
    tick();

    mem_wait = 0;
    read_lit(8'h01, 1'b0, 6);
    read_lit(8'h00, 1'b1, 2);
    read_lit(8'h02, 1'b1, 2);
    read_lit(8'h03, 1'b1, 2);
    read_lit(8'h72, 1'b0, 6);
    read_lit(8'h73, 1'b1, 2);
    read_lit(8'h12, 1'b0, 6);
    read_lit(8'h72, 1'b0, 6);

    do_flush(1'b1);
    read_lit(8'h00, 1'b0, 6);

    mem_wait = 3;
    read_lit(8'h05, 1'b0, 18);

    mem_wait = 0;
    start_read(8'h40);
    for (int n = 0; n < 50 && aq.size() > 2; n++) tick();
    chk("beats_before_reset", aq.size(), 2);
    rst_n = 1'b0;
    rq.delete();
    aq.delete();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    held = 8'h00;
    #1;
    chk("midrefill_mem_req", mem_req, 0);
    chk("midrefill_cpu_valid", cpu_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    read_lit(8'h41, 1'b0, 6);

    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_flush(1'($urandom_range(0, 1)));
      end else begin
        mem_wait = $urandom_range(0, 3);
        do_read(8'($urandom) & 8'h3F);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end

    wait_idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
